// File: rtl/dp_sched_pkg.sv
// Shared types for the data plane tx scheduler: FSM states, id/packet widths, timer helper.
// Pure definitions; no latency and no backpressure of its own.
package dp_sched_pkg;

  localparam int ID_W  = 16;
  localparam int PKT_W = 32;
  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESERVE,
    ST_WAIT_ACK,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_FAIL
  } state_t;

  // Saturating increment so a stuck timer never wraps back under its threshold.
  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/data_plane_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set req bit at or after ptr, cyclically; one-hot and index out.
// Purely combinational, zero latency; no backpressure (gnt is zero when req is zero).
module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] idx
);

  logic            found;
  logic [IDXW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDXW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/data_plane_tx_scheduler.sv
// Shares the data plane transmitter: arbitrate, reserve via control plane, launch, await completion.
// Latency: grant 1 cycle after req, strobe 1 later; requesters hold req until done/fail (no other backpressure).
module data_plane_tx_scheduler
  import dp_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ACK_TIMEOUT  = 15,
  parameter int MAX_RETRY    = 3,
  parameter int DONE_TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_W-1:0]         node_id,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*ID_W-1:0] req_dest,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      fail,
  output logic                    ctrl_tx_valid,
  output logic [PKT_W-1:0]        ctrl_tx_packet,
  input  logic                    ctrl_ack,
  input  logic [ID_W-1:0]         ctrl_ack_src,
  output logic                    data_tx_flag,
  input  logic                    data_tx_complete_flag,
  output logic                    busy
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [TMR_W-1:0] ACK_TO  = TMR_W'(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] DONE_TO = TMR_W'(DONE_TIMEOUT);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   dest_q;
  logic [IDXW-1:0]   rr_ptr;
  logic [7:0]        retry_q;
  logic [TMR_W-1:0]  timer_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDXW-1:0]    arb_idx;
  logic [ID_W-1:0]    arb_dest;
  logic [TMR_W-1:0]   timer_inc;
  logic [7:0]         retry_inc;
  logic               ack_hit, ack_to, done_to, self_dest;

  rr_arbiter #(.N(NUM_REQ), .IDXW(IDXW)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign arb_dest  = req_dest[arb_idx*ID_W +: ID_W];
  assign timer_inc = sat_inc(timer_q);
  assign retry_inc = retry_q + 8'd1;
  // Timeouts fire when the count being written reaches the threshold.
  assign ack_to    = (timer_inc >= ACK_TO);
  assign done_to   = (timer_inc >= DONE_TO);
  assign ack_hit   = ctrl_ack && (ctrl_ack_src == dest_q);
  assign self_dest = (dest_q == node_id);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (|req) state_d = ST_RESERVE;
      ST_RESERVE:   state_d = self_dest ? ST_FAIL : ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ack_hit)     state_d = ST_LAUNCH;
        else if (ack_to) state_d = (retry_inc < RETRY_MAX) ? ST_RESERVE : ST_FAIL;
      end
      ST_LAUNCH:    state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (data_tx_complete_flag) state_d = ST_RELEASE;
        else if (done_to)          state_d = ST_FAIL;
      end
      ST_RELEASE,
      ST_FAIL:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_tx_flag = (state_q == ST_LAUNCH);
    done         = (state_q == ST_RELEASE) ? grant : '0;
    fail         = (state_q == ST_FAIL)    ? grant : '0;
    busy         = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant          <= '0;
      dest_q         <= '0;
      rr_ptr         <= '0;
      retry_q        <= '0;
      timer_q        <= '0;
      ctrl_tx_valid  <= 1'b0;
      ctrl_tx_packet <= '0;
    end else begin
      ctrl_tx_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (|req) begin
            grant  <= arb_gnt;
            dest_q <= arb_dest;
            rr_ptr <= (arb_idx == IDXW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
          end
        end
        ST_RESERVE: begin
          timer_q <= '0;
          // A self-addressed request never reaches the control plane.
          if (!self_dest) begin
            ctrl_tx_valid  <= 1'b1;
            ctrl_tx_packet <= {dest_q, node_id};
          end
        end
        ST_WAIT_ACK: begin
          timer_q <= timer_inc;
          if (!ack_hit && ack_to) retry_q <= retry_inc;
        end
        ST_LAUNCH:    timer_q <= '0;
        ST_WAIT_DONE: timer_q <= timer_inc;
        ST_RELEASE,
        ST_FAIL: begin
          grant   <= '0;
          retry_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_plane_tx_scheduler.sv
// Directed bench for data_plane_tx_scheduler with hand-computed expectations.
module tb_data_plane_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] node_id;
  logic [3:0]  req;
  logic [63:0] req_dest;
  logic [3:0]  grant, done, fail;
  logic        ctrl_tx_valid;
  logic [31:0] ctrl_tx_packet;
  logic        ctrl_ack;
  logic [15:0] ctrl_ack_src;
  logic        data_tx_flag;
  logic        data_tx_complete_flag;
  logic        busy;

  logic        auto_mode;
  logic        ack_m, complete_m;
  logic [15:0] ack_src_m;
  logic        ack_a = 1'b0, complete_a = 1'b0, flag_d = 1'b0;
  logic [15:0] ack_src_a = 16'h0;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int n_strobe = 0, n_flag = 0, n_done = 0, n_fail = 0;
  int strobe_t[$];
  logic [3:0] gq[$];
  int gt[$];
  logic [3:0] grant_prev = 4'h0;

  assign ctrl_ack              = auto_mode ? ack_a      : ack_m;
  assign ctrl_ack_src          = auto_mode ? ack_src_a  : ack_src_m;
  assign data_tx_complete_flag = auto_mode ? complete_a : complete_m;

  data_plane_tx_scheduler #(
    .NUM_REQ(4), .ACK_TIMEOUT(15), .MAX_RETRY(3), .DONE_TIMEOUT(31)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .node_id               (node_id),
    .req                   (req),
    .req_dest              (req_dest),
    .grant                 (grant),
    .done                  (done),
    .fail                  (fail),
    .ctrl_tx_valid         (ctrl_tx_valid),
    .ctrl_tx_packet        (ctrl_tx_packet),
    .ctrl_ack              (ctrl_ack),
    .ctrl_ack_src          (ctrl_ack_src),
    .data_tx_flag          (data_tx_flag),
    .data_tx_complete_flag (data_tx_complete_flag),
    .busy                  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log plus an instant responder: ack in the strobe cycle, complete one cycle after launch.
  always @(negedge clk) begin
    if (ctrl_tx_valid) begin
      n_strobe++;
      strobe_t.push_back(cyc);
    end
    if (data_tx_flag) n_flag++;
    if (|done) n_done++;
    if (|fail) n_fail++;
    if (grant != 4'h0 && grant_prev == 4'h0) begin
      gq.push_back(grant);
      gt.push_back(cyc);
    end
    grant_prev = grant;
    ack_a      = ctrl_tx_valid;
    ack_src_a  = ctrl_tx_packet[31:16];
    complete_a = flag_d;
    flag_d     = data_tx_flag;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(input string tag);
    int k = 0;
    while (!ctrl_tx_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_vec(tag, {31'b0, ctrl_tx_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_vec(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int b_str, b_flag, b_done, b_fail, sb, gb, t_fail, k;
    logic [3:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b0; req = 4'h0; req_dest = 64'h0; node_id = 16'h0001;
    ack_m = 1'b0; ack_src_m = 16'h0; complete_m = 1'b0; auto_mode = 1'b0;
    #1;
    check_vec("rst_grant",  {28'b0, grant}, 32'h0);
    check_vec("rst_done",   {28'b0, done}, 32'h0);
    check_vec("rst_fail",   {28'b0, fail}, 32'h0);
    check_vec("rst_valid",  {31'b0, ctrl_tx_valid}, 32'h0);
    check_vec("rst_packet", ctrl_tx_packet, 32'h0);
    check_vec("rst_flag",   {31'b0, data_tx_flag}, 32'h0);
    check_vec("rst_busy",   {31'b0, busy}, 32'h0);
    step(2);
    rst = 1'b1;
    step(1);

    // Single request from requester 2 to node 5.
    b_str = n_strobe; b_flag = n_flag; b_done = n_done;
    req_dest[2*16 +: 16] = 16'h0005;
    req = 4'b0100;
    step(1);
    check_vec("t1_grant", {28'b0, grant}, 32'h4);
    check_vec("t1_no_strobe_yet", {31'b0, ctrl_tx_valid}, 32'h0);
    step(1);
    check_vec("t1_strobe", {31'b0, ctrl_tx_valid}, 32'h1);
    check_vec("t1_packet", ctrl_tx_packet, 32'h0005_0001);
    step(2);
    ack_m = 1'b1; ack_src_m = 16'h0005;
    step(1);
    ack_m = 1'b0;
    check_vec("t1_launch", {31'b0, data_tx_flag}, 32'h1);
    step(1);
    check_vec("t1_launch_one_cycle", {31'b0, data_tx_flag}, 32'h0);
    step(3);
    complete_m = 1'b1;
    step(1);
    complete_m = 1'b0;
    check_vec("t1_done", {28'b0, done}, 32'h4);
    check_vec("t1_grant_held", {28'b0, grant}, 32'h4);
    req = 4'h0;
    step(1);
    check_vec("t1_grant_clear", {28'b0, grant}, 32'h0);
    check_vec("t1_idle", {31'b0, busy}, 32'h0);
    check_vec("t1_strobe_count", n_strobe - b_str, 32'd1);
    check_vec("t1_flag_count", n_flag - b_flag, 32'd1);
    check_vec("t1_done_count", n_done - b_done, 32'd1);

    // Wrong-source ack ignored; dest change after grant ignored; complete during launch ignored.
    req_dest[0 +: 16] = 16'h0005;
    req = 4'b0001;
    wait_strobe("t2_wait_strobe");
    ack_m = 1'b1; ack_src_m = 16'h0007;
    req_dest[0 +: 16] = 16'h0009;
    step(1);
    ack_m = 1'b0;
    check_vec("t2_wrong_ack_no_launch", {31'b0, data_tx_flag}, 32'h0);
    check_vec("t2_wrong_ack_busy", {31'b0, busy}, 32'h1);
    step(2);
    ack_m = 1'b1; ack_src_m = 16'h0005;
    step(1);
    ack_m = 1'b0;
    check_vec("t2_launch_latched_dest", {31'b0, data_tx_flag}, 32'h1);
    complete_m = 1'b1;
    step(1);
    complete_m = 1'b0;
    check_vec("t2_complete_in_launch", {28'b0, done}, 32'h0);
    step(2);
    check_vec("t2_still_waiting", {31'b0, busy}, 32'h1);
    complete_m = 1'b1;
    step(1);
    complete_m = 1'b0;
    check_vec("t2_done", {28'b0, done}, 32'h1);
    req = 4'h0;
    step(1);
    check_vec("t2_idle", {31'b0, busy}, 32'h0);

    // Self-addressed request fails without a reservation packet.
    b_str = n_strobe;
    req_dest[3*16 +: 16] = 16'h0001;
    req = 4'b1000;
    step(1);
    check_vec("t3_grant", {28'b0, grant}, 32'h8);
    check_vec("t3_no_fail_yet", {28'b0, fail}, 32'h0);
    step(1);
    check_vec("t3_fail", {28'b0, fail}, 32'h8);
    check_vec("t3_no_strobe", {31'b0, ctrl_tx_valid}, 32'h0);
    req = 4'h0;
    step(1);
    check_vec("t3_grant_clear", {28'b0, grant}, 32'h0);
    check_vec("t3_strobe_count", n_strobe - b_str, 32'd0);

    // No ack at all: three strobes 16 cycles apart, then fail.
    b_flag = n_flag;
    sb = strobe_t.size();
    req_dest[1*16 +: 16] = 16'h0005;
    req = 4'b0010;
    k = 0;
    while (!(|fail) && k < 120) begin
      @(negedge clk);
      k++;
    end
    t_fail = cyc;
    check_vec("t4_fail", {28'b0, fail}, 32'h2);
    check_vec("t4_grant_at_fail", {28'b0, grant}, 32'h2);
    req = 4'h0;
    check_vec("t4_strobe_count", strobe_t.size() - sb, 32'd3);
    if (strobe_t.size() >= sb + 3) begin
      check_vec("t4_spacing_1", strobe_t[sb+1] - strobe_t[sb], 32'd16);
      check_vec("t4_spacing_2", strobe_t[sb+2] - strobe_t[sb+1], 32'd16);
      check_vec("t4_fail_delay", t_fail - strobe_t[sb+2], 32'd15);
    end
    check_vec("t4_no_launch", n_flag - b_flag, 32'd0);
    step(1);
    check_vec("t4_idle", {31'b0, busy}, 32'h0);

    // Asynchronous reset while waiting for completion; pointer restarts at 0.
    req_dest[2*16 +: 16] = 16'h0005;
    req = 4'b0100;
    wait_strobe("t5_wait_strobe");
    ack_m = 1'b1; ack_src_m = 16'h0005;
    step(1);
    ack_m = 1'b0;
    step(1);
    check_vec("t5_in_wait_done", {28'b0, grant}, 32'h4);
    #1 rst = 1'b0;
    #1;
    check_vec("t5_rst_grant",  {28'b0, grant}, 32'h0);
    check_vec("t5_rst_busy",   {31'b0, busy}, 32'h0);
    check_vec("t5_rst_packet", ctrl_tx_packet, 32'h0);
    check_vec("t5_rst_flag",   {31'b0, data_tx_flag}, 32'h0);
    req = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    req_dest[1*16 +: 16] = 16'h0006;
    req_dest[3*16 +: 16] = 16'h0006;
    req = 4'b1010;
    step(1);
    check_vec("t5_ptr_from_zero", {28'b0, grant}, 32'h2);
    auto_mode = 1'b1;
    req = 4'h0;
    wait_idle("t5_drain");

    // Fairness with all four requesting and an instant responder.
    apply_reset();
    req_dest = {16'h0004, 16'h0003, 16'h0002, 16'h0005};
    b_done = n_done; b_fail = n_fail;
    gb = gq.size();
    req = 4'b1111;
    k = 0;
    while (gq.size() < gb + 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    req = 4'h0;
    wait_idle("t6_drain");
    check_vec("t6_grant_count", gq.size() - gb, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (gq.size() > gb + i)
        check_vec($sformatf("t6_order_%0d", i), {28'b0, gq[gb+i]}, {28'b0, exp_order[i]});
    end
    if (gt.size() >= gb + 2)
      check_vec("t6_turnaround", gt[gb+1] - gt[gb], 32'd6);
    check_vec("t6_done_count", n_done - b_done, 32'd5);
    check_vec("t6_fail_count", n_fail - b_fail, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/data_plane_tx_scheduler.md
# data_plane_tx_scheduler

Sequences and shares the node's single data plane transmitter between several local requesters (GPP threads or DMA sources). It round-robin arbitrates pending requests and sends a reservation packet on the control plane. It waits for the destination's acknowledge, then pulses `data_tx_flag` into the data plane transmitter and holds the grant until `data_tx_complete_flag` returns, with timeouts and bounded retries. It sits between the requesters, the control plane tx/rx and the data plane tx.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ACK_TIMEOUT`, 15: cycles to wait for a reservation acknowledge.
- `MAX_RETRY`, 3: reservation attempts before failing a request.
- `DONE_TIMEOUT`, 31: cycles to wait for `data_tx_complete_flag` after launch.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low (asserted at 0).
- `node_id` in 16: this node's id.
- `req` in NUM_REQ: level request per requester; held until its `done` or `fail`.
- `req_dest` in NUM_REQ×16: destination node id per requester.
- `grant` out NUM_REQ: one-hot owner of the transmitter, or zero.
- `done` out NUM_REQ: one-cycle pulse on successful transmission.
- `fail` out NUM_REQ: one-cycle pulse on abort.
- `ctrl_tx_valid` out 1: one-cycle strobe of a reservation packet.
- `ctrl_tx_packet` out 32: {dest[15:0], node_id[15:0]}.
- `ctrl_ack` in 1: one-cycle acknowledge strobe from control plane rx.
- `ctrl_ack_src` in 16: node id that sent the acknowledge.
- `data_tx_flag` out 1: one-cycle launch pulse to the data plane tx.
- `data_tx_complete_flag` in 1: completion pulse from the data plane tx.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values: state IDLE, `grant`=0, `done`=0, `fail`=0, `ctrl_tx_valid`=0, `ctrl_tx_packet`=0, `data_tx_flag`=0, `busy`=0, rr pointer=0, retry=0, timer=0.
- **IDLE**: if any `req` bit is set, select the first set bit at or after the rr pointer, cyclically. Latch its index and `req_dest`, set `grant`, go to RESERVE. Set rr pointer = (index+1) mod NUM_REQ.
- **Self-addressed request**: if the latched dest equals `node_id`, pulse `fail` and return to IDLE. No packet is sent.
- **RESERVE**: drive `ctrl_tx_valid`=1 and `ctrl_tx_packet`={dest,node_id} for one cycle. Clear the timer and go to WAIT_ACK.
- **WAIT_ACK**:
  - `ctrl_ack` with `ctrl_ack_src`==dest: go to LAUNCH.
  - `ctrl_ack` with a non-matching source: ignored.
  - Timer reaches ACK_TIMEOUT: retry+1. If retry < MAX_RETRY, go to RESERVE; otherwise go to FAIL.
- **LAUNCH**: `data_tx_flag`=1 for exactly one cycle. Clear the timer and go to WAIT_DONE.
- **WAIT_DONE**: `data_tx_complete_flag` goes to RELEASE with `done`. Timer reaching DONE_TIMEOUT goes to FAIL.
- **RELEASE / FAIL**: pulse `done` or `fail` for the granted index, clear `grant` and retry, return to IDLE.
- A requester dropping `req` mid-operation does not abort; the operation runs to completion and the `done`/`fail` pulse is still issued.
- `req_dest` changes after grant are ignored (latched copy is used).
- Async reset mid-operation: all outputs return to reset values immediately. An in-flight data plane transfer is not the scheduler's responsibility.

## Timing
- Arbitration latency: `req` sampled high in IDLE at edge N gives `grant` valid after edge N and `ctrl_tx_valid` after edge N+1.
- `ctrl_ack` is accepted only in WAIT_ACK. If `ctrl_ack` arrives on the first WAIT_ACK cycle, `data_tx_flag` pulses one cycle later.
- `done`/`fail` are asserted for one cycle while `grant` is still set. `grant` clears on the following edge.
- Minimum turnaround: IDLE→IDLE takes 5 cycles when the ack arrives immediately.
- Timer is 8 bits and saturating. The timeout compare is ≥.
- The LAUNCH cycle has priority: a `data_tx_complete_flag` arriving in LAUNCH is ignored.
- A simultaneous ack and timeout in the same cycle: the ack wins.

## Structure
- Shared package `dp_sched_pkg`: state enum (IDLE, RESERVE, WAIT_ACK, LAUNCH, WAIT_DONE, RELEASE, FAIL) and the packet field widths (ID 16, packet 32).
- Sub-module `rr_arbiter #(N)`: combinational round-robin pick from `req` and `ptr`, producing a one-hot and an index output.

## Test plan
- Single request: `req[2]`=1, dest=0x0005, node_id=0x0001, ack from 0x0005 after 3 cycles, complete after 5 cycles → packet 0x00050001, one `data_tx_flag` pulse, `done[2]` pulse, `grant` returns to 0.
- Fairness: `req`=4'b1111 held continuously with instant ack/complete → grants in order 0,1,2,3,0.
- Ack timeout: no ack → exactly 3 reservation strobes spaced ACK_TIMEOUT+1 apart, then `fail[idx]` and no `data_tx_flag`.
- Wrong ack: ack from 0x0007 while the dest is 0x0005 → ignored. A correct ack later → launch.
- Self-dest: dest==node_id → `fail` 1 cycle after grant, with no `ctrl_tx_valid`.
- Reset in WAIT_DONE: drive `rst`=0 asynchronously → all outputs 0 before the next edge. After release, a new request is served from rr pointer 0.
